// File: rtl/stack_ctrl.sv
// Push/pop controller for a byte stack held in data memory.
// The stack pointer lives in a register-file entry.
module stack_ctrl #(
  parameter int unsigned SP_REG = 29,
  parameter logic [7:0]  SP_TOP = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] push_data,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] pop_data,
  output logic [4:0] rf_addr,
  output logic [7:0] rf_wdata,
  output logic       rf_we,
  input  logic [7:0] rf_rdata,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  input  logic [7:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD_SP,
    MEM,
    WR_SP,
    DONE
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       op_push;
  logic [7:0] data_q;
  logic [7:0] sp;
  logic [7:0] nsp;
  logic [7:0] pop_q;
  logic       err_q;
  logic       accept;
  logic       conflict;
  logic       fault;

  assign accept   = (state == IDLE) && (push ^ pop);
  assign conflict = (state == IDLE) && push && pop;
  // Bounds check uses the live read so an abort leaves RD_SP directly.
  assign fault    = op_push ? (rf_rdata == 8'h00)
                            : (rf_rdata == SP_TOP);
  assign nsp      = op_push ? (sp - 8'd1) : (sp + 8'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (accept) state_nxt = RD_SP;
      RD_SP: state_nxt = fault ? IDLE : MEM;
      MEM:   state_nxt = WR_SP;
      WR_SP: state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_push <= 1'b0;
      data_q  <= 8'h00;
      sp      <= SP_TOP;
      pop_q   <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      err_q <= conflict || ((state == RD_SP) && fault);
      if (accept) begin
        op_push <= push;
        data_q  <= push_data;
      end
      if (state == RD_SP) sp <= rf_rdata;
      if ((state == MEM) && !op_push) pop_q <= mem_rdata;
    end
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = 1'b0;
    err       = err_q;
    pop_data  = pop_q;
    rf_addr   = 5'(SP_REG);
    rf_wdata  = 8'h00;
    rf_we     = 1'b0;
    mem_addr  = 8'h00;
    mem_wdata = 8'h00;
    mem_we    = 1'b0;
    unique case (1'b1)
      (state == MEM): begin
        mem_addr = op_push ? nsp : sp;
        if (op_push) begin
          mem_wdata = data_q;
          mem_we    = 1'b1;
        end
      end
      (state == WR_SP): begin
        rf_wdata = nsp;
        rf_we    = 1'b1;
      end
      (state == DONE): done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a register-file and
// data-memory model around it.
module tb_stack_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [7:0] push_data = 8'h00;
  logic       busy, done, err, rf_we, mem_we;
  logic [7:0] pop_data, rf_wdata, rf_rdata;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [4:0] rf_addr;

  bit [7:0] rf [32];
  bit [7:0] mem [256];
  logic       pre_we = 1'b0;
  logic [7:0] pre_val = 8'h00;

  int n_chk = 0;
  int n_fail = 0;

  stack_ctrl #(.SP_REG(29), .SP_TOP(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n),
    .push(push), .pop(pop), .push_data(push_data),
    .busy(busy), .done(done), .err(err),
    .pop_data(pop_data),
    .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .rf_we(rf_we), .rf_rdata(rf_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign rf_rdata  = rf[rf_addr];
  assign mem_rdata = mem[mem_addr];

  // Register file commits on the falling edge.
  always @(negedge clk) begin
    if (pre_we) rf[29] <= pre_val;
    else if (rf_we) rf[rf_addr] <= rf_wdata;
  end

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  typedef struct {
    bit         pre;
    logic [7:0] pre_sp;
    bit         psh;
    bit         pp;
    logic [7:0] d;
    bit         e_err;
    bit         e_done;
    logic [7:0] e_pd;
    logic [7:0] e_sp;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int n_err = 0;
    int n_done = 0;
    int n_rfw = 0;
    int n_mw = 0;
    int dcyc = 0;
    logic b1 = 1'b0;
    pre_we  = v.pre;
    pre_val = v.pre_sp;
    @(negedge clk);
    pre_we    = 1'b0;
    push      = v.psh;
    pop       = v.pp;
    push_data = v.d;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) b1 = busy;
      if (err) n_err++;
      if (done) begin
        n_done++;
        if (dcyc == 0) dcyc = c;
      end
      if (rf_we) n_rfw++;
      if (mem_we) n_mw++;
    end
    chk({nm, " busy"}, 32'(b1), 32'(v.psh ^ v.pp));
    chk({nm, " err"}, n_err, 32'(v.e_err));
    chk({nm, " done"}, n_done, 32'(v.e_done));
    chk({nm, " done_cyc"}, dcyc, v.e_done ? 4 : 0);
    chk({nm, " rf_we"}, n_rfw, 32'(v.e_done));
    chk({nm, " mem_we"}, n_mw, 32'(v.e_done && v.psh));
    chk({nm, " pop_data"}, 32'(pop_data), 32'(v.e_pd));
    chk({nm, " reg29"}, 32'(rf[29]), 32'(v.e_sp));
    if (v.e_done && v.psh)
      chk({nm, " mem"}, 32'(mem[v.e_sp]), 32'(v.d));
  endtask

  initial begin
    int n_rfw;
    int n_done;
    //        pre sp     psh pp d      err done pd     sp
    tbl[0]  = '{1, 8'hFF, 0, 1, 8'h00, 1, 0, 8'h00, 8'hFF};
    tbl[1]  = '{0, 8'h00, 1, 0, 8'hA5, 0, 1, 8'h00, 8'hFE};
    tbl[2]  = '{0, 8'h00, 0, 1, 8'h00, 0, 1, 8'hA5, 8'hFF};
    tbl[3]  = '{0, 8'h00, 1, 0, 8'h11, 0, 1, 8'hA5, 8'hFE};
    tbl[4]  = '{0, 8'h00, 1, 0, 8'h22, 0, 1, 8'hA5, 8'hFD};
    tbl[5]  = '{0, 8'h00, 1, 0, 8'h33, 0, 1, 8'hA5, 8'hFC};
    tbl[6]  = '{0, 8'h00, 0, 1, 8'h00, 0, 1, 8'h33, 8'hFD};
    tbl[7]  = '{0, 8'h00, 0, 1, 8'h00, 0, 1, 8'h22, 8'hFE};
    tbl[8]  = '{0, 8'h00, 0, 1, 8'h00, 0, 1, 8'h11, 8'hFF};
    tbl[9]  = '{1, 8'h00, 1, 0, 8'h44, 1, 0, 8'h11, 8'h00};
    tbl[10] = '{1, 8'hFF, 1, 1, 8'h55, 1, 0, 8'h11, 8'hFF};

    #12;
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst err", 32'(err), 0);
    chk("rst we", 32'({rf_we, mem_we}), 0);
    chk("rst pop_data", 32'(pop_data), 0);
    chk("rst wdata", 32'({rf_wdata, mem_wdata}), 0);
    chk("rst rf_addr", 32'(rf_addr), 29);
    chk("rst mem_addr", 32'(mem_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++)
      run_vec(tbl[i], $sformatf("v%0d", i));

    // Pop raised while a push is busy must be dropped.
    @(negedge clk);
    push = 1'b1;
    push_data = 8'h5A;
    @(posedge clk);
    #1;
    push = 1'b0;
    n_rfw = 0;
    n_done = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      pop = (c == 1);
      if (rf_we) n_rfw++;
      if (done) n_done++;
    end
    pop = 1'b0;
    chk("busy_ign rf_we", n_rfw, 1);
    chk("busy_ign done", n_done, 1);
    chk("busy_ign reg29", 32'(rf[29]), 32'h FE);
    chk("busy_ign mem", 32'(mem[8'hFE]), 32'h5A);

    // Reset in the middle of a push's memory cycle.
    @(negedge clk);
    push = 1'b1;
    push_data = 8'h77;
    @(posedge clk);
    #1;
    push = 1'b0;
    @(posedge clk);
    #2;
    chk("mid mem_we", 32'(mem_we), 1);
    rst_n = 1'b0;
    #1;
    chk("mid busy", 32'(busy), 0);
    chk("mid we", 32'({rf_we, mem_we}), 0);
    chk("mid done_err", 32'({done, err}), 0);
    chk("mid pop_data", 32'(pop_data), 0);
    chk("mid wdata", 32'({rf_wdata, mem_wdata}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("mid reg29", 32'(rf[29]), 32'hFE);
    chk("mid mem", 32'(mem[8'hFD]), 32'h22);
    run_vec('{0, 8'h00, 1, 0, 8'h88, 0, 1, 8'h00, 8'hFD}, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
